pipe_fetch_q: RTL and testbench
===============================

// Module: pipe_fetch_q
// PURPOSE
//  Instruction fetch queue: consumer end of the PC/instruction-memory fetch path.
//  Buffers {pc, inst} pairs produced each cycle by the PC register + imem read and
//  hands them to the ID stage in order. Back-pressures the PC via wpc (PC write
//  enable) when full; discards wrong-path words on a taken branch/jump flush.
//  Sits between imem read data and the IF/ID decode logic of the pipelined CPU.
// PARAMETERS
//  DEPTH   4    number of entries; power of two, >= 2
//  AW      2    log2(DEPTH); pointer width
//  XLEN    32   pc / instruction width
// PORTS
//  clk       in   1       clock; all state updates on rising edge
//  clr       in   1       reset, synchronous, active-high
//  if_valid  in   1       if_pc/if_inst hold a fetched word this cycle
//  if_pc     in   XLEN    address of fetched word
//  if_inst   in   XLEN    fetched instruction word
//  wpc       out  1       PC write enable; 0 = hold PC (queue cannot accept)
//  flush     in   1       taken branch/jump: discard all queued and incoming words
//  id_take   in   1       ID consumes head entry this cycle (ignored when empty)
//  d_valid   out  1       head entry valid
//  d_pc      out  XLEN    head entry pc
//  d_inst    out  XLEN    head entry instruction
//  d_pc4     out  XLEN    d_pc + 4
//  count     out  AW+1    number of valid entries, 0..DEPTH
// BEHAVIOUR
//  - State: storage array [DEPTH] of {pc,inst}, rd_ptr/wr_ptr (AW bits, wrap
//    DEPTH-1 -> 0), count register (AW+1 bits). full = (count==DEPTH), empty = (count==0).
//  - Reset (clr=1 at edge): rd_ptr=0, wr_ptr=0, count=0; hence d_valid=0, d_pc=0,
//    d_inst=0, d_pc4=4, wpc=1. Array contents need not be cleared. clr overrides all.
//  - deq = id_take & ~empty.  enq = if_valid & ~flush & (~full | deq).
//  - wpc = ~full | deq (combinational; includes id_take path). wpc=1 whenever flush=1
//    so the PC loads the branch target.
//  - On edge, no flush: enq writes array[wr_ptr], wr_ptr++; deq rd_ptr++;
//    count += enq - deq. enq & deq together: count unchanged; legal when full
//    (head leaves, new word lands in freed slot) and when count==1.
//  - Flush (flush=1, clr=0): rd_ptr=wr_ptr=0, count=0; incoming word dropped; an
//    id_take in the same cycle is a don't-care (queue empties regardless).
//  - Empty + enq: word visible on d_* the cycle after the edge (1-cycle latency);
//    no combinational fall-through from if_* to d_*.
//  - Outputs combinational from array[rd_ptr]: d_valid = ~empty; when empty,
//    d_pc=0 and d_inst=0 (0x00000000 = NOP), so ID never decodes stale data.
//  - d_pc4 = d_pc + 4, truncated to XLEN: 0xFFFFFFFC -> 0x00000000.
//  - Order strictly FIFO; no entry duplicated or lost except by flush/clr.
//  - if_valid=1 with wpc=0: word not accepted; PC held, same word re-presented.
// TESTING
//  1 clr=1 one edge -> count=0, d_valid=0, d_inst=0, d_pc4=4, wpc=1.
//  2 Push pc 0x0,0x4,0x8,0xC (inst 0x20080001..4), id_take=0 -> count=4, wpc=0;
//    5th word 0x10 held off; then id_take=1 one cycle -> d_pc=0x4, 0x10 accepted, count=4.
//  3 Continuous if_valid & id_take from empty, pc 0x100.. -> count stays 1 after
//    first edge, d_pc sequence 0x100,0x104,0x108 one per cycle, wpc=1 throughout.
//  4 Queue holding 3 entries, flush=1 with if_valid=1 pc 0x40 -> next cycle count=0,
//    d_valid=0; following push pc 0x200 -> d_pc=0x200 (0x40 never appears).
//  5 Push pc 0xFFFFFFFC -> d_pc4=0x00000000; pointer wrap: 10 push/pop pairs with
//    DEPTH=4 -> data order preserved across wr_ptr/rd_ptr wrap.
//  6 clr=1 while full and id_take=1, if_valid=1 -> next cycle count=0, d_valid=0;
//    random push/pop/flush run checked against a reference queue model.

Source files
------------

// File: rtl/pipe_fetch_q.sv
// rtl/pipe_fetch_q.sv - instruction fetch queue between imem read data and ID
// Buffers {pc, inst} pairs in order, throttles the PC through wpc, and drops everything on flush.
module pipe_fetch_q #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    output logic            wpc,
    input  logic            flush,
    input  logic            id_take,
    output logic            d_valid,
    output logic [XLEN-1:0] d_pc,
    output logic [XLEN-1:0] d_inst,
    output logic [XLEN-1:0] d_pc4,
    output logic [AW:0]     count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full, empty, deq, enq;

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        deq   = id_take & ~empty;
        // A full queue still accepts when the head leaves in the same cycle.
        enq   = if_valid & ~flush & (~full | deq);
        wpc   = ~full | deq | flush;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !clr) begin
            pc_mem_q[wr_ptr_q]   <= if_pc;
            inst_mem_q[wr_ptr_q] <= if_inst;
        end
    end

    // Empty queue presents a NOP at pc 0 so ID never decodes stale storage.
    always_comb begin
        d_valid = ~empty;
        d_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
        d_inst  = empty ? '0 : inst_mem_q[rd_ptr_q];
        d_pc4   = d_pc + XLEN'(4);
        count   = count_q;
    end

endmodule

// File: tb/tb_pipe_fetch_q.sv
// tb/tb_pipe_fetch_q.sv - self-checking bench for pipe_fetch_q
// Table vectors, directed corner sequences and a random run against a queue model.
module tb_pipe_fetch_q;

    logic        clk = 1'b0;
    logic        clr, if_valid, flush, id_take;
    logic [31:0] if_pc, if_inst;
    logic        wpc, d_valid;
    logic [31:0] d_pc, d_inst, d_pc4;
    logic [2:0]  count;

    pipe_fetch_q #(.DEPTH(4), .AW(2), .XLEN(32)) dut (
        .clk(clk), .clr(clr), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .wpc(wpc), .flush(flush), .id_take(id_take), .d_valid(d_valid),
        .d_pc(d_pc), .d_inst(d_inst), .d_pc4(d_pc4), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } word_t;
    word_t model_q[$];
    bit    model_ok = 0;
    logic  wpc_pre;

    typedef struct {
        bit          c, f, v, t;
        logic [31:0] pc, inst;
        bit          chk_wpc;
        bit          exp_wpc;
        int          exp_count;
        bit          exp_valid;
        logic [31:0] exp_pc, exp_inst;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] epc, einst;
        epc   = (model_q.size() > 0) ? model_q[0].pc : 32'h0;
        einst = (model_q.size() > 0) ? model_q[0].inst : 32'h0;
        chk("count", 32'(count), 32'(model_q.size()));
        chk("d_valid", 32'(d_valid), 32'(model_q.size() > 0));
        chk("d_pc", d_pc, epc);
        chk("d_inst", d_inst, einst);
        chk("d_pc4", d_pc4, epc + 32'd4);
    endtask

    // One clock: apply inputs, check wpc mid-cycle, clock, advance model, check outputs.
    task automatic cyc(input bit c, input bit f, input bit v, input bit t,
                       input logic [31:0] pc, input logic [31:0] inst);
        bit m_full, m_empty, accept;
        clr = c; flush = f; if_valid = v; id_take = t; if_pc = pc; if_inst = inst;
        #4;
        m_full  = (model_q.size() == 4);
        m_empty = (model_q.size() == 0);
        accept  = v && !f && (!m_full || (t && !m_empty));
        if (model_ok && !c)
            chk("wpc", 32'(wpc), 32'(f || !m_full || (t && !m_empty)));
        wpc_pre = wpc;
        @(posedge clk);
        if (c || f) begin
            model_q.delete();
        end else begin
            if (t && !m_empty) void'(model_q.pop_front());
            if (accept) model_q.push_back({pc, inst});
        end
        if (c) model_ok = 1;
        #1;
        if (model_ok) check_model();
    endtask

    initial begin
        clr = 1'b0; flush = 1'b0; if_valid = 1'b0; id_take = 1'b0;
        if_pc = '0; if_inst = '0;

        // Reset, fill to full, hold off a fifth word, then take one to admit it.
        tbl[0] = '{1, 0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0, 32'h0};
        tbl[1] = '{0, 0, 1, 0, 32'h0,  32'h20080001, 1, 1, 1, 1, 32'h0, 32'h20080001};
        tbl[2] = '{0, 0, 1, 0, 32'h4,  32'h20080002, 1, 1, 2, 1, 32'h0, 32'h20080001};
        tbl[3] = '{0, 0, 1, 0, 32'h8,  32'h20080003, 1, 1, 3, 1, 32'h0, 32'h20080001};
        tbl[4] = '{0, 0, 1, 0, 32'hC,  32'h20080004, 1, 1, 4, 1, 32'h0, 32'h20080001};
        tbl[5] = '{0, 0, 1, 0, 32'h10, 32'h20080005, 1, 0, 4, 1, 32'h0, 32'h20080001};
        tbl[6] = '{0, 0, 1, 1, 32'h10, 32'h20080005, 1, 1, 4, 1, 32'h4, 32'h20080002};

        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].c, tbl[i].f, tbl[i].v, tbl[i].t, tbl[i].pc, tbl[i].inst);
            if (tbl[i].chk_wpc) chk($sformatf("tbl%0d wpc", i), 32'(wpc_pre), 32'(tbl[i].exp_wpc));
            chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d d_valid", i), 32'(d_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d d_pc", i), d_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d d_inst", i), d_inst, tbl[i].exp_inst);
            chk($sformatf("tbl%0d d_pc4", i), d_pc4, tbl[i].exp_valid ? tbl[i].exp_pc + 32'd4 : 32'd4);
        end
        // The held word 0x10 must have landed at the tail.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'h0, 32'h0);
        chk("held word at head", d_pc, 32'h10);

        // Streaming from empty: one word in, one word out each cycle.
        cyc(1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
            chk("stream wpc", 32'(wpc_pre), 32'd1);
            chk("stream count", 32'(count), 32'd1);
            chk("stream d_pc", d_pc, 32'h100 + 32'(i * 4));
        end

        // Flush with three queued words and an incoming word.
        cyc(1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'(i * 4), 32'hB000 + 32'(i));
        cyc(0, 1, 1, 0, 32'h40, 32'hDEAD0040);
        chk("flush wpc", 32'(wpc_pre), 32'd1);
        chk("flush count", 32'(count), 32'd0);
        chk("flush d_valid", 32'(d_valid), 32'd0);
        cyc(0, 0, 1, 0, 32'h200, 32'hC0000200);
        chk("post-flush d_pc", d_pc, 32'h200);
        cyc(0, 0, 0, 1, 32'h0, 32'h0);
        chk("0x40 dropped", 32'(d_valid), 32'd0);

        // d_pc4 wrap, then pointer wrap with overlapped push/pop.
        cyc(1, 0, 0, 0, 32'h0, 32'h0);
        cyc(0, 0, 1, 0, 32'hFFFFFFFC, 32'h13);
        chk("pc4 wrap", d_pc4, 32'h0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 32'h300 + 32'(i * 4), 32'hE000 + 32'(i));
        chk("wrap d_pc", d_pc, 32'h300 + 32'(9 * 4));

        // clr dominates a full queue with take and incoming word.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 32'h500 + 32'(i * 4), 32'hF000 + 32'(i));
        chk("full count", 32'(count), 32'd4);
        cyc(1, 0, 1, 1, 32'h600, 32'h1);
        chk("clr count", 32'(count), 32'd0);
        chk("clr d_valid", 32'(d_valid), 32'd0);
        chk("clr wpc", 32'(wpc), 32'd1);

        // Random push/pop/flush/clr against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                ($urandom_range(3) != 0), ($urandom_range(1) == 1),
                {$urandom_range(32'h3FFFFFFF), 2'b00}, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
